// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the data memory port
// of the data memory arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the surrounding system (requesters plus memory).
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the processor (M0,
// fixed priority) and the host/DMA loader (M1). M1 is guaranteed one grant
// after STARVE_LIMIT consecutive blocked cycles. Grants are combinational;
// read data is captured from the memory and returned one cycle after the grant.
module dmem_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {
    NORMAL,
    FORCE1
  } state_t;

  state_t        state;
  logic [7:0]    starve_cnt;
  logic [7:0]    cnt_next;
  logic          grant0;
  logic          grant1;
  logic          mem_we_mux;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  // Grant selection: M0 wins normally, M1 wins for the single forced cycle; nothing during reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      case (state)
        NORMAL: begin
          if (bus.m0_req)      grant0 = 1'b1;
          else if (bus.m1_req) grant1 = 1'b1;
        end
        FORCE1: begin
          if (bus.m1_req)      grant1 = 1'b1;
          else if (bus.m0_req) grant0 = 1'b1;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign bus.m0_gnt = grant0;
  assign bus.m1_gnt = grant1;

  // Memory port steering: the granted master's address and data, zeros when idle
  always_comb begin
    mem_we_mux = 1'b0;
    addr_mux   = '0;
    wdata_mux  = '0;
    if (grant0) begin
      mem_we_mux = bus.m0_we;
      addr_mux   = bus.m0_addr;
      wdata_mux  = bus.m0_wdata;
    end else if (grant1) begin
      mem_we_mux = bus.m1_we;
      addr_mux   = bus.m1_addr;
      wdata_mux  = bus.m1_wdata;
    end
  end

  assign bus.mem_we    = mem_we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  // Starvation count for the coming edge: grows while M1 waits, clears once it is served or gives up
  always_comb begin
    cnt_next = starve_cnt;
    if (!bus.m1_req || grant1) begin
      cnt_next = 8'd0;
    end else if (starve_cnt < LIMIT) begin
      cnt_next = starve_cnt + 8'd1;
    end
  end

  // Arbitration FSM: enter FORCE1 when the count reaches the limit, leave after one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= 8'd0;
    end else begin
      starve_cnt <= cnt_next;
      case (state)
        NORMAL: if (cnt_next == LIMIT) state <= FORCE1;
        FORCE1: state <= NORMAL;
        default: state <= NORMAL;
      endcase
    end
  end

  // Read return: capture memory data for a granted read and flag it valid for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m0_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rvalid <= 1'b0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.m0_rvalid <= grant0 & ~bus.m0_we;
      bus.m1_rvalid <= grant1 & ~bus.m1_we;
      if (grant0 && !bus.m0_we) bus.m0_rdata <= bus.mem_rdata;
      if (grant1 && !bus.m1_we) bus.m1_rdata <= bus.mem_rdata;
    end
  end

endmodule
